// File: rtl/con_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | con_mem_pkg                                                      |
// | Shared types, byte-lane constants and lane helper for con_mem.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package con_mem_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_e;

   localparam logic [3:0] c_BE_BYTE = 4'b0001;
   localparam logic [3:0] c_BE_HALF = 4'b0011;
   localparam logic [3:0] c_BE_WORD = 4'b1111;

   // Byte lane an access starts on; halves ignore a[0], words ignore both bits.
   function automatic logic [1:0] lane_shift(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [1:0] r;
      case (size)
         MEM_B:   r = addr_lo;
         MEM_H:   r = {addr_lo[1], 1'b0};
         default: r = 2'b00;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/con_mem_load_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_load_align                                                   |
// | Shifts the raw load word down to its lane and sign/zero extends. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_load_align
   import con_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  shift,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [31:0] w_shifted;

   assign w_shifted = rdata >> {shift, 3'b000};

   always_comb begin
      data = w_shifted;
      case (size)
         MEM_B:   data = is_unsigned ? {24'd0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
         MEM_H:   data = is_unsigned ? {16'd0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: data = w_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/con_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | con_mem                                                          |
// | MEM stage: EX/MEM latch, data-memory handshake, load alignment,  |
// | registered writeback. Option macro: CON_MEM_MISALIGN_TRAP_EN.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module con_mem
   import con_mem_pkg::*;
#(
   parameter int WORD_SIZE = 32
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid,
   input  logic                 branch_taken_in,
   input  logic [4:0]           rdn_in,
   input  logic [WORD_SIZE-1:0] pc_in,
   input  logic [WORD_SIZE-1:0] branch_addr_in,
   input  logic [WORD_SIZE-1:0] alu_out_in,
   input  logic [WORD_SIZE-1:0] rs2d_in,
   input  logic                 mem_rd,
   input  logic                 mem_wr,
   input  logic [1:0]           mem_size,
   input  logic                 mem_unsigned,
   output logic                 mem_stall,
   output logic                 dmem_req_valid,
   input  logic                 dmem_req_ready,
   output logic                 dmem_we,
   output logic [WORD_SIZE-1:0] dmem_addr,
   output logic [WORD_SIZE-1:0] dmem_wdata,
   output logic [3:0]           dmem_be,
   input  logic                 dmem_rsp_valid,
   input  logic [WORD_SIZE-1:0] dmem_rsp_rdata,
   output logic                 wb_valid,
   output logic                 wb_we,
   output logic [4:0]           wb_rdn,
   output logic [WORD_SIZE-1:0] wb_data,
   output logic [WORD_SIZE-1:0] wb_pc,
   output logic [WORD_SIZE-1:0] wb_branch_addr,
   output logic                 wb_branch_taken,
   output logic                 misalign_trap
);

   logic                 r_lat_valid, r_lat_taken, r_lat_rd, r_lat_wr, r_lat_unsigned;
   logic [4:0]           r_lat_rdn;
   logic [1:0]           r_lat_size;
   logic [WORD_SIZE-1:0] r_lat_pc, r_lat_baddr, r_lat_alu, r_lat_rs2;
   mem_state_e           r_state, w_state_nxt;
   logic                 w_is_load, w_is_store, w_misalign, w_req, w_complete;
   logic [1:0]           w_shift;
   logic [3:0]           w_be;
   logic [WORD_SIZE-1:0] w_wdata, w_load_data;

   // Both rd and wr set is decoded as a load.
   assign w_is_load  = r_lat_rd;
   assign w_is_store = r_lat_wr & ~r_lat_rd;

`ifdef CON_MEM_MISALIGN_TRAP_EN
   assign w_misalign = (w_is_load | w_is_store) &
                       (((r_lat_size == MEM_H) & r_lat_alu[0]) |
                        ((r_lat_size != MEM_B) & (r_lat_size != MEM_H) & (r_lat_alu[1:0] != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_shift = lane_shift(r_lat_size, r_lat_alu[1:0]);

   always_comb begin
      w_be    = c_BE_WORD;
      w_wdata = r_lat_rs2;
      case (r_lat_size)
         MEM_B: begin
            w_be    = c_BE_BYTE << w_shift;
            w_wdata = {4{r_lat_rs2[7:0]}};
         end
         MEM_H: begin
            w_be    = c_BE_HALF << w_shift;
            w_wdata = {2{r_lat_rs2[15:0]}};
         end
         default: begin
            w_be    = c_BE_WORD;
            w_wdata = r_lat_rs2;
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_lat_valid) begin
               if ((w_is_load | w_is_store) & ~w_misalign) begin
                  w_req = 1'b1;
                  if (dmem_req_ready) begin
                     if (w_is_store) w_complete  = 1'b1;
                     else            w_state_nxt = WAIT;
                  end else begin
                     w_state_nxt = REQ;
                  end
               end else begin
                  w_complete = 1'b1;
               end
            end
         end
         REQ: begin
            w_req = 1'b1;
            if (dmem_req_ready) begin
               if (w_is_store) begin
                  w_complete  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (dmem_rsp_valid) begin
               w_complete  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign mem_stall      = r_lat_valid & ~w_complete;
   assign dmem_req_valid = w_req;
   assign dmem_we        = w_req & w_is_store;
   assign dmem_addr      = w_req ? {r_lat_alu[WORD_SIZE-1:2], 2'b00} : '0;
   assign dmem_wdata     = w_req ? w_wdata : '0;
   assign dmem_be        = w_req ? w_be : 4'b0000;

   mem_load_align u_align (
      .rdata       (dmem_rsp_rdata),
      .shift       (w_shift),
      .size        (r_lat_size),
      .is_unsigned (r_lat_unsigned),
      .data        (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Latch holds while stalled; a completing instruction frees it for same-cycle recapture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lat_valid    <= 1'b0;
         r_lat_taken    <= 1'b0;
         r_lat_rd       <= 1'b0;
         r_lat_wr       <= 1'b0;
         r_lat_unsigned <= 1'b0;
         r_lat_rdn      <= '0;
         r_lat_size     <= '0;
         r_lat_pc       <= '0;
         r_lat_baddr    <= '0;
         r_lat_alu      <= '0;
         r_lat_rs2      <= '0;
      end else if (!mem_stall) begin
         r_lat_valid    <= ex_valid;
         r_lat_taken    <= branch_taken_in;
         r_lat_rd       <= mem_rd;
         r_lat_wr       <= mem_wr;
         r_lat_unsigned <= mem_unsigned;
         r_lat_rdn      <= rdn_in;
         r_lat_size     <= mem_size;
         r_lat_pc       <= pc_in;
         r_lat_baddr    <= branch_addr_in;
         r_lat_alu      <= alu_out_in;
         r_lat_rs2      <= rs2d_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid        <= 1'b0;
         wb_we           <= 1'b0;
         misalign_trap   <= 1'b0;
         wb_rdn          <= '0;
         wb_data         <= '0;
         wb_pc           <= '0;
         wb_branch_addr  <= '0;
         wb_branch_taken <= 1'b0;
      end else begin
         wb_valid      <= w_complete;
         wb_we         <= w_complete & ~w_is_store & ~w_misalign & (r_lat_rdn != 5'd0);
         misalign_trap <= w_complete & w_misalign;
         if (w_complete) begin
            wb_rdn          <= r_lat_rdn;
            wb_data         <= (w_is_load & ~w_misalign) ? w_load_data : r_lat_alu;
            wb_pc           <= r_lat_pc;
            wb_branch_addr  <= r_lat_baddr;
            wb_branch_taken <= r_lat_taken;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_con_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_con_mem                                                       |
// | Scoreboard bench for con_mem: expected retires queued at issue.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_con_mem;

   logic        clk, rst;
   logic        ex_valid, branch_taken_in, mem_rd, mem_wr, mem_unsigned;
   logic [4:0]  rdn_in;
   logic [31:0] pc_in, branch_addr_in, alu_out_in, rs2d_in;
   logic [1:0]  mem_size;
   logic        mem_stall, dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rsp_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_we, wb_branch_taken, misalign_trap;
   logic [4:0]  wb_rdn;
   logic [31:0] wb_data, wb_pc, wb_branch_addr;

   typedef struct {
      logic        we;
      logic [4:0]  rdn;
      logic [31:0] data;
      logic [31:0] pc;
      logic [31:0] baddr;
      logic        taken;
      logic        trap;
   } wb_exp_t;

   wb_exp_t     sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        mon_en  = 1'b0;
   logic [31:0] pc_ctr  = 32'h0000_1000;
   int          stall_cnt;

   con_mem dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .branch_taken_in(branch_taken_in),
      .rdn_in(rdn_in), .pc_in(pc_in), .branch_addr_in(branch_addr_in),
      .alu_out_in(alu_out_in), .rs2d_in(rs2d_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_stall(mem_stall),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rdn(wb_rdn), .wb_data(wb_data),
      .wb_pc(wb_pc), .wb_branch_addr(wb_branch_addr), .wb_branch_taken(wb_branch_taken),
      .misalign_trap(misalign_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Retire monitor: every wb_valid pulse must match the oldest queued expectation.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (sb_q.size() == 0) begin
            check_val("wb_spurious", {31'd0, wb_valid}, 32'd0);
         end else if (wb_valid) begin
            wb_exp_t e;
            e = sb_q.pop_front();
            check_val("wb_data",  wb_data, e.data);
            check_val("wb_we",    {31'd0, wb_we}, {31'd0, e.we});
            check_val("wb_rdn",   {27'd0, wb_rdn}, {27'd0, e.rdn});
            check_val("wb_pc",    wb_pc, e.pc);
            check_val("wb_baddr", wb_branch_addr, e.baddr);
            check_val("wb_taken", {31'd0, wb_branch_taken}, {31'd0, e.taken});
            check_val("wb_trap",  {31'd0, misalign_trap}, {31'd0, e.trap});
         end
      end
   end

   task automatic issue(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rdn,
                        input logic push, input logic [31:0] exp_data, input logic exp_we,
                        input logic exp_trap);
      wb_exp_t e;
      @(negedge clk);
      ex_valid        = 1'b1;
      mem_rd          = rd;
      mem_wr          = wr;
      mem_size        = size;
      mem_unsigned    = uns;
      alu_out_in      = alu;
      rs2d_in         = rs2;
      rdn_in          = rdn;
      pc_in           = pc_ctr;
      branch_addr_in  = pc_ctr + 32'h40;
      branch_taken_in = pc_ctr[2];
      if (push) begin
         e.we = exp_we; e.rdn = rdn; e.data = exp_data; e.pc = pc_ctr;
         e.baddr = pc_ctr + 32'h40; e.taken = pc_ctr[2]; e.trap = exp_trap;
         sb_q.push_back(e);
      end
      pc_ctr = pc_ctr + 32'd4;
   endtask

   // Memory side of one access: ready held low n_lo cycles, response n_wait cycles after acceptance.
   task automatic mem_access(input int n_lo, input int n_wait, input logic is_load,
                             input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                             output int stalls);
      stalls = 0;
      for (int i = 0; i <= n_lo; i++) begin
         @(negedge clk);
         ex_valid       = 1'b0;
         dmem_req_ready = (i == n_lo);
         #1;
         check_val("req_valid", {31'd0, dmem_req_valid}, 32'd1);
         check_val("req_addr",  dmem_addr, exp_addr);
         check_val("req_we",    {31'd0, dmem_we}, {31'd0, !is_load});
         if (!is_load) begin
            check_val("req_wdata", dmem_wdata, exp_wdata);
            check_val("req_be",    {28'd0, dmem_be}, {28'd0, exp_be});
         end
         if (mem_stall) stalls++;
      end
      if (is_load) begin
         for (int j = 0; j <= n_wait; j++) begin
            @(negedge clk);
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = (j == n_wait);
            dmem_rsp_rdata = rdata;
            #1;
            check_val("wait_req_low", {31'd0, dmem_req_valid}, 32'd0);
            if (mem_stall) stalls++;
         end
      end
      @(negedge clk);
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ex_valid = 1'b0; branch_taken_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      mem_unsigned = 1'b0; rdn_in = '0; pc_in = '0; branch_addr_in = '0; alu_out_in = '0;
      rs2d_in = '0; mem_size = 2'b00; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
      check_val("rst_stall",     {31'd0, mem_stall}, 32'd0);
      check_val("rst_wb_valid",  {31'd0, wb_valid}, 32'd0);
      check_val("rst_wb_data",   wb_data, 32'd0);
      check_val("rst_be",        {28'd0, dmem_be}, 32'd0);
      check_val("rst_trap",      {31'd0, misalign_trap}, 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // ALU op: retire exactly two cycles after issue, never stalls
      issue(0, 0, 2'b10, 0, 32'h1234, 32'h0, 5'd5, 1, 32'h1234, 1, 0);
      @(negedge clk); ex_valid = 1'b0; #1;
      check_val("alu_wb_c1", {31'd0, wb_valid}, 32'd0);
      check_val("alu_stall", {31'd0, mem_stall}, 32'd0);
      check_val("alu_noreq", {31'd0, dmem_req_valid}, 32'd0);
      @(negedge clk);
      check_val("alu_wb_c2", {31'd0, wb_valid}, 32'd1);

      // Stores: byte, half, word lanes
      issue(0, 1, 2'b00, 0, 32'h103, 32'hAB, 5'd7, 1, 32'h103, 0, 0);
      mem_access(0, 0, 0, 32'h0, 32'h100, 32'hABABABAB, 4'b1000, stall_cnt);
      check_val("sb_stalls", stall_cnt, 32'd0);
      issue(0, 1, 2'b01, 0, 32'h102, 32'h5678, 5'd7, 1, 32'h102, 0, 0);
      mem_access(0, 0, 0, 32'h0, 32'h100, 32'h56785678, 4'b1100, stall_cnt);
      issue(0, 1, 2'b10, 0, 32'h204, 32'hCAFEF00D, 5'd8, 1, 32'h204, 0, 0);
      mem_access(0, 0, 0, 32'h0, 32'h204, 32'hCAFEF00D, 4'b1111, stall_cnt);

      // Loads: sign/zero extension and lane selection
      issue(1, 0, 2'b00, 0, 32'h102, 32'h0, 5'd9, 1, 32'hFFFFFF80, 1, 0);
      mem_access(0, 0, 1, 32'h0080_0000, 32'h100, 32'h0, 4'h0, stall_cnt);
      check_val("lb_stalls", stall_cnt, 32'd1);
      issue(1, 0, 2'b00, 1, 32'h102, 32'h0, 5'd10, 1, 32'h00000080, 1, 0);
      mem_access(0, 0, 1, 32'h0080_0000, 32'h100, 32'h0, 4'h0, stall_cnt);
      issue(1, 0, 2'b01, 0, 32'h102, 32'h0, 5'd11, 1, 32'hFFFF8001, 1, 0);
      mem_access(0, 0, 1, 32'h8001_0000, 32'h100, 32'h0, 4'h0, stall_cnt);
      issue(1, 0, 2'b01, 1, 32'h102, 32'h0, 5'd12, 1, 32'h00008001, 1, 0);
      mem_access(0, 0, 1, 32'h8001_0000, 32'h100, 32'h0, 4'h0, stall_cnt);
      issue(1, 0, 2'b10, 0, 32'h200, 32'h0, 5'd0, 1, 32'hDEADBEEF, 0, 0);
      mem_access(0, 0, 1, 32'hDEADBEEF, 32'h200, 32'h0, 4'h0, stall_cnt);
      // rd and wr both set behaves as a load
      issue(1, 1, 2'b10, 0, 32'h208, 32'h5555, 5'd13, 1, 32'h0BADF00D, 1, 0);
      mem_access(0, 0, 1, 32'h0BADF00D, 32'h208, 32'h0, 4'h0, stall_cnt);

      // Back-pressure: ready low 3 cycles, response 1 cycle after acceptance
      issue(1, 0, 2'b10, 0, 32'h300, 32'h0, 5'd3, 1, 32'h11223344, 1, 0);
      mem_access(3, 1, 1, 32'h11223344, 32'h300, 32'h0, 4'h0, stall_cnt);
      check_val("bp_stalls", stall_cnt, 32'd5);

      // Back-to-back ALU ops retire one per cycle
      issue(0, 0, 2'b10, 0, 32'hA1, 32'h0, 5'd1, 1, 32'hA1, 1, 0);
      issue(0, 0, 2'b10, 0, 32'hA2, 32'h0, 5'd2, 1, 32'hA2, 1, 0);
      issue(0, 0, 2'b10, 0, 32'hA3, 32'h0, 5'd0, 1, 32'hA3, 0, 0);
      #1;
      check_val("b2b_wb_c2", {31'd0, wb_valid}, 32'd1);
      @(negedge clk); ex_valid = 1'b0; #1;
      check_val("b2b_wb_c3", {31'd0, wb_valid}, 32'd1);
      check_val("b2b_stall", {31'd0, mem_stall}, 32'd0);
      @(negedge clk);
      check_val("b2b_wb_c4", {31'd0, wb_valid}, 32'd1);
      @(negedge clk);
      check_val("b2b_wb_c5", {31'd0, wb_valid}, 32'd0);

`ifdef CON_MEM_MISALIGN_TRAP_EN
      issue(1, 0, 2'b10, 0, 32'h102, 32'h0, 5'd4, 1, 32'h102, 0, 1);
      @(negedge clk); ex_valid = 1'b0; dmem_req_ready = 1'b1; #1;
      check_val("mis_noreq", {31'd0, dmem_req_valid}, 32'd0);
      check_val("mis_stall", {31'd0, mem_stall}, 32'd0);
      @(negedge clk); dmem_req_ready = 1'b0;
      check_val("mis_trap", {31'd0, misalign_trap}, 32'd1);
      check_val("mis_wbv",  {31'd0, wb_valid}, 32'd1);
`else
      // Without the trap, a word access ignores the low address bits entirely
      issue(1, 0, 2'b10, 0, 32'h102, 32'h0, 5'd4, 1, 32'hA5A50001, 1, 0);
      mem_access(0, 0, 1, 32'hA5A50001, 32'h100, 32'h0, 4'h0, stall_cnt);
`endif

      // Reset while waiting for a load response; the late response must be dropped
      issue(1, 0, 2'b10, 0, 32'h400, 32'h0, 5'd6, 0, 32'h0, 0, 0);
      @(negedge clk); ex_valid = 1'b0; dmem_req_ready = 1'b1; #1;
      check_val("rw_req", {31'd0, dmem_req_valid}, 32'd1);
      @(negedge clk); dmem_req_ready = 1'b0; #1;
      check_val("rw_wait_req", {31'd0, dmem_req_valid}, 32'd0);
      check_val("rw_wait_stall", {31'd0, mem_stall}, 32'd1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      check_val("rw_req_after", {31'd0, dmem_req_valid}, 32'd0);
      check_val("rw_stall_after", {31'd0, mem_stall}, 32'd0);
      check_val("rw_wbdata_after", wb_data, 32'd0);
      dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h77777777;
      @(negedge clk); dmem_rsp_valid = 1'b0;
      check_val("rw_stale_rsp", {31'd0, wb_valid}, 32'd0);

      repeat (3) @(negedge clk);
      check_val("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
